prog_loader: RTL

- Boot-time stage directly upstream of cpu_wrap.
- Takes a byte stream from the UART receiver, assembles little-endian 32-bit instruction words and writes them into instruction memory.
- Holds the core in reset until the image is fully written, then releases it by driving the core's active-low rstn.

---
 rtl/prog_loader.sv | 100 ++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// prog_loader: boot loader turning a UART byte stream into instruction-memory writes, then releasing the core.
// Optional checksum byte after the data words is enabled with PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
   parameter int ADDR_W    = 12,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_rstn,
   output logic              busy,
   output logic              err
);
   typedef enum logic [2:0] {HDR, DATA, DONE, ERR
`ifdef PROG_LOADER_CHECKSUM_EN
      , CSUM
`endif
   } state_t;
   localparam logic [31:0]       MAX_WORDS = 32'(1) << ADDR_W;
   localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W:0]   ONE       = 1;
`ifdef PROG_LOADER_CHECKSUM_EN
   localparam state_t FIN = CSUM;
`else
   localparam state_t FIN = DONE;
`endif
   state_t          state, state_n;
   logic [1:0]      byte_cnt;
   logic [23:0]     shift;
   logic [ADDR_W:0] len, word_idx;
   logic            acc, last;
   logic [31:0]     word;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0]      sum;
   assign rx_ready = state == HDR || state == DATA || state == CSUM;
`else
   assign rx_ready = state == HDR || state == DATA;
`endif
   assign busy = rx_ready;
   assign err  = state == ERR;
   assign acc  = rx_valid && rx_ready;
   assign last = acc && byte_cnt == 2'd3;
   assign word = {rx_data, shift};

   // State register
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= HDR;
      else     state <= state_n;

   // Next state: header length check, last-word detection, checksum verdict
   always_comb begin
      state_n = state;
      case (state)
         HDR:  if (last) state_n = word > MAX_WORDS ? ERR : word == 32'd0 ? FIN : DATA;
         DATA: if (last && word_idx == len - ONE) state_n = FIN;
`ifdef PROG_LOADER_CHECKSUM_EN
         CSUM: if (acc) state_n = rx_data == sum ? DONE : ERR;
`endif
         default: ;
      endcase
   end

   // Byte assembly, word writes and core reset release one cycle after DONE is entered
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         byte_cnt   <= '0;
         shift      <= '0;
         len        <= '0;
         word_idx   <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= BASE;
         imem_wdata <= '0;
         cpu_rstn   <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
         sum        <= '0;
`endif
      end else begin
         imem_we  <= 1'b0;
         cpu_rstn <= state == DONE;
         if (acc && (state == HDR || state == DATA)) begin
            byte_cnt <= byte_cnt + 2'd1;
            shift    <= {rx_data, shift[23:8]};
         end
         if (last && state == HDR) len <= word[ADDR_W:0];
         if (last && state == DATA) begin
            imem_we    <= 1'b1;
            imem_wdata <= word;
            imem_addr  <= BASE + word_idx[ADDR_W-1:0];
            word_idx   <= word_idx + ONE;
         end
`ifdef PROG_LOADER_CHECKSUM_EN
         if (acc && state == DATA) sum <= sum + rx_data;
`endif
      end
endmodule
